pll_lock_supervisor: RTL



---
 rtl/pll_sup_pkg.sv | 29 ++
 rtl/pll_sup_sync2.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and width helpers for the PLL lock supervisor.
// Latency: n/a; backpressure: n/a.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // Bits needed to count 0..value-1; never narrower than one bit.
    function automatic int width_of(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
// Latency: 2 cycles; backpressure: none.
module pll_sup_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer, lock qualifier, retry/fault handling and mon_clk frequency check.
// Latency: outputs registered, 2-cycle input sync; backpressure: none.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 125,
    parameter int LOCK_TIMEOUT_CYCLES = 1250000,
    parameter int LOCK_STABLE_CYCLES  = 12500,
    parameter int MAX_RETRIES         = 7,
    parameter int MON_WINDOW          = 125000,
    parameter int MON_EXPECT          = 1000,
    parameter int MON_TOL             = 2
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               mon_clk,
    input  logic               clear_fault,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               lock_ok,
    output logic               freq_ok,
    output logic [RETRY_W-1:0] retry_count,
    output logic [LOSS_W-1:0]  loss_count,
    output logic               fault
);

    localparam int TIMER_W  = width_of(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));
    localparam int WIN_W    = width_of(MON_WINDOW);
    localparam int EDGE_MAX = 2 * MON_EXPECT;
    localparam int EDGE_W   = width_of(EDGE_MAX + 1);
    localparam int DIFF_W   = EDGE_W + 1;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [WIN_W-1:0]   WIN_LAST     = WIN_W'(MON_WINDOW - 1);
    localparam logic [EDGE_W-1:0]  EDGE_SAT     = EDGE_W'(EDGE_MAX);

    localparam logic signed [DIFF_W-1:0] EXPECT_S = DIFF_W'(MON_EXPECT);
    localparam logic signed [DIFF_W-1:0] TOL_S    = DIFF_W'(MON_TOL);

    state_t               state;
    state_t               next_state;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;
    logic [RETRY_W-1:0]   retry_nxt;
    logic [LOSS_W-1:0]    loss_nxt;
    logic                 pll_rst_nxt;
    logic                 sys_rst_nxt;
    logic                 lock_ok_nxt;
    logic                 fault_nxt;

    logic                 locked_s;
    logic                 mon_s;
    logic                 mon_s_d;
    logic                 mon_edge;
    logic [WIN_W-1:0]     win_cnt;
    logic [EDGE_W-1:0]    edge_cnt;
    logic [EDGE_W-1:0]    edges_total;
    logic signed [DIFF_W-1:0] edge_diff;
    logic                 in_tol;

    pll_sup_sync2 u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    pll_sup_sync2 u_sync_mon (
        .clk (refclk),
        .rst (rst),
        .d   (mon_clk),
        .q   (mon_s)
    );

    // State register; outputs are registered from the next state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= PLL_RESET;
            timer       <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            lock_ok     <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state       <= next_state;
            timer       <= timer_nxt;
            pll_rst     <= pll_rst_nxt;
            sys_rst     <= sys_rst_nxt;
            lock_ok     <= lock_ok_nxt;
            fault       <= fault_nxt;
            retry_count <= retry_nxt;
            loss_count  <= loss_nxt;
        end
    end

    always_comb begin
        next_state = state;
        timer_nxt  = '0;
        retry_nxt  = retry_count;
        unique case (state)
            PLL_RESET: begin
                if (timer == RST_LAST) next_state = WAIT_LOCK;
                else                   timer_nxt  = timer + 1'b1;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = STABILIZE;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_nxt  = retry_count + 1'b1;
                    next_state = (retry_nxt >= RETRY_LIMIT) ? FAULT : PLL_RESET;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            STABILIZE: begin
                // Any unlocked cycle restarts the full lock wait without a retry.
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (timer == STABLE_LAST) begin
                    next_state = RUN;
                    retry_nxt  = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) next_state = PLL_RESET;
            end
            FAULT: begin
                if (clear_fault) begin
                    next_state = PLL_RESET;
                    retry_nxt  = '0;
                end
            end
            default: next_state = PLL_RESET;
        endcase
    end

    always_comb begin
        pll_rst_nxt = (next_state == PLL_RESET) || (next_state == FAULT);
        sys_rst_nxt = (next_state != RUN);
        lock_ok_nxt = (next_state == RUN);
        fault_nxt   = (next_state == FAULT);
        loss_nxt    = loss_count;
        if ((state == RUN) && (next_state == PLL_RESET) && (loss_count != '1))
            loss_nxt = loss_count + 1'b1;
    end

    // Frequency monitor: edges counted per fixed refclk window while in RUN.
    assign mon_edge    = mon_s & ~mon_s_d;
    assign edges_total = (edge_cnt == EDGE_SAT) ? edge_cnt : edge_cnt + EDGE_W'(mon_edge);
    assign edge_diff   = $signed({1'b0, edges_total}) - EXPECT_S;
    assign in_tol      = (edge_diff <= TOL_S) && (edge_diff >= -TOL_S);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            mon_s_d  <= 1'b0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            freq_ok  <= 1'b0;
        end else begin
            mon_s_d <= mon_s;
            if ((state != RUN) || (next_state != RUN)) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
                freq_ok  <= 1'b0;
            end else if (win_cnt == WIN_LAST) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
                freq_ok  <= in_tol;
            end else begin
                win_cnt  <= win_cnt + 1'b1;
                edge_cnt <= edges_total;
            end
        end
    end

endmodule
